// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the instruction memory (slave).
// The read is combinational: imem_data reflects imem_addr within the same cycle.
interface if_fetch_stage_if #(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 32
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, PC+1, redirect/stall handling and the IF/ID register.
// Optional performance counters are built when IF_FETCH_PERF_CNT_EN is defined.
module if_fetch_stage #(
  parameter int                 PC_W      = 7,
  parameter int                 INSTR_W   = 32,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_pc,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_pc,
  if_fetch_stage_if.master   imem,
  output logic [PC_W-1:0]    pc_next,
  output logic [PC_W-1:0]    if_id_pc_next,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [15:0]        flush_count
`endif
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    if_id_pc_next_q, if_id_pc_next_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic               if_id_valid_q, if_id_valid_d;
  logic               redirect;
  logic               load_real;

  // Only pc feeds the address and PC+1; control inputs act on the next edge.
  assign imem.imem_addr = pc_q;
  assign pc_next        = pc_q + 1'b1;

  // Branch outranks jump, and either redirect outranks stall.
  assign redirect  = branch_taken | jump;
  assign load_real = !redirect && !stall;

  always_comb begin
    pc_d            = pc_q;
    if_id_pc_next_d = if_id_pc_next_q;
    if_id_instr_d   = if_id_instr_q;
    if_id_valid_d   = if_id_valid_q;
    if (branch_taken) begin
      pc_d = branch_pc;
    end else if (jump) begin
      pc_d = jump_pc;
    end else if (!stall) begin
      pc_d = pc_next;
    end
    if (redirect) begin
      if_id_instr_d   = NOP_INSTR;
      if_id_pc_next_d = '0;
      if_id_valid_d   = 1'b0;
    end else if (load_real) begin
      if_id_instr_d   = imem.imem_data;
      if_id_pc_next_d = pc_next;
      if_id_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q            <= RESET_PC;
      if_id_pc_next_q <= '0;
      if_id_instr_q   <= NOP_INSTR;
      if_id_valid_q   <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      if_id_pc_next_q <= if_id_pc_next_d;
      if_id_instr_q   <= if_id_instr_d;
      if_id_valid_q   <= if_id_valid_d;
    end
  end

  assign if_id_pc_next = if_id_pc_next_q;
  assign if_id_instr   = if_id_instr_q;
  assign if_id_valid   = if_id_valid_q;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [15:0] flush_count_q, flush_count_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    fetch_count_d = fetch_count_q;
    flush_count_d = flush_count_q;
    if (load_real && (fetch_count_q != '1)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
    if (redirect && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule
